// File: rtl/spi_shifter_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module : spi_shifter_gen_pkg
// Desc   : Shared types and helpers for the parametrised SPI slave shifter.
// Rev    : 1.0 - initial release
// ============================================================================
package spi_shifter_gen_pkg;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // Data is sampled on the rising sck edge when CPOL and CPHA agree.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol ^ cpha) == 1'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : spi_tx_fifo
// Desc   : Synchronous transmit FIFO; pointers carry one extra wrap bit.
// Rev    : 1.0 - initial release
// ============================================================================
module spi_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             wr_vld,
  output logic             wr_rdy,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             overrun
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             push;
  logic             pop;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_rdy = !full;
  assign push   = wr_vld && !full;
  assign pop    = rd_en && !empty;
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // A push into a full FIFO is dropped even when a pop frees a slot this cycle.
      overrun <= wr_vld && full;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spi_shifter_gen.sv
`default_nettype none
// ============================================================================
// Module : spi_shifter_gen
// Desc   : Oversampled SPI slave shifter, any CPOL/CPHA, width and bit order.
// Rev    : 1.0 - initial release
// ============================================================================
module spi_shifter_gen
  import spi_shifter_gen_pkg::*;
#(
  parameter int WORD_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int TX_DEPTH    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ssn,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [WORD_W-1:0] rx_dat,
  output logic              rx_vld,
  input  logic [WORD_W-1:0] tx_dat,
  input  logic              tx_vld,
  output logic              tx_rdy,
  output logic              start,
  output logic              frame_end,
  output logic              rx_partial,
  output logic              tx_underrun,
  output logic              tx_overrun,
  output logic              busy
);
  localparam int               CNT_W       = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WORD_W - 1);
  localparam logic             SCK_IDLE    = (CPOL != 0);
  localparam logic             SAMPLE_RISE = sample_on_rise(CPOL != 0, CPHA != 0);

  logic [SYNC_STAGES-1:0] sck_sync, ssn_sync, mosi_sync;
  logic                   sck_prev, ssn_prev;
  logic                   sck_s, ssn_s, mosi_s;
  logic                   sample_edge, shift_edge, ssn_fall, ssn_rise;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic               word_start;
  logic [WORD_W-1:0]  rx_sh, rx_next;
  logic [WORD_W-1:0]  tx_reg, tx_shifted;
  logic [WORD_W-1:0]  fifo_dat;
  logic               fifo_empty;
  logic               load;

  // ssn synchroniser resets low so a frame in progress at reset is never joined.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
      ssn_sync  <= '0;
      mosi_sync <= '0;
      sck_prev  <= SCK_IDLE;
      ssn_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], ssn};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
      ssn_prev  <= ssn_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s       = sck_sync[SYNC_STAGES-1];
  assign ssn_s       = ssn_sync[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync[SYNC_STAGES-1];
  assign sample_edge = SAMPLE_RISE ? (sck_s && !sck_prev) : (!sck_s && sck_prev);
  assign shift_edge  = SAMPLE_RISE ? (!sck_s && sck_prev) : (sck_s && !sck_prev);
  assign ssn_fall    = !ssn_s && ssn_prev;
  assign ssn_rise    = ssn_s && !ssn_prev;

  assign rx_next    = (MSB_FIRST != 0) ? {rx_sh[WORD_W-2:0], mosi_s} : {mosi_s, rx_sh[WORD_W-1:1]};
  assign tx_shifted = (MSB_FIRST != 0) ? {tx_reg[WORD_W-2:0], 1'b0} : {1'b0, tx_reg[WORD_W-1:1]};

  always_comb begin
    load = 1'b0;
    if (state == IDLE)
      load = ssn_fall && (CPHA == 0);
    else if (state == ACTIVE && !ssn_rise && shift_edge)
      load = (CPHA == 0) ? word_start : (bit_cnt == '0);
  end

  spi_tx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (TX_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_dat  (tx_dat),
    .wr_vld  (tx_vld),
    .wr_rdy  (tx_rdy),
    .rd_en   (load),
    .rd_dat  (fifo_dat),
    .empty   (fifo_empty),
    .overrun (tx_overrun)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RESYNC;
      bit_cnt     <= '0;
      word_start  <= 1'b0;
      rx_sh       <= '0;
      rx_dat      <= '0;
      rx_vld      <= 1'b0;
      tx_reg      <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      busy        <= 1'b0;
      start       <= 1'b0;
      frame_end   <= 1'b0;
      rx_partial  <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      start       <= 1'b0;
      frame_end   <= 1'b0;
      rx_partial  <= 1'b0;
      rx_vld      <= 1'b0;
      tx_underrun <= 1'b0;
      if (load) begin
        tx_reg      <= fifo_empty ? '0 : fifo_dat;
        tx_underrun <= fifo_empty;
      end
      case (state)
        RESYNC: if (ssn_s) state <= IDLE;
        IDLE: begin
          if (ssn_fall) begin
            state      <= ACTIVE;
            start      <= 1'b1;
            busy       <= 1'b1;
            miso_oe    <= 1'b1;
            bit_cnt    <= '0;
            word_start <= 1'b0;
          end
        end
        ACTIVE: begin
          if (ssn_rise) begin
            state      <= IDLE;
            frame_end  <= 1'b1;
            rx_partial <= (bit_cnt != '0);
            busy       <= 1'b0;
            miso_oe    <= 1'b0;
          end else if (sample_edge) begin
            rx_sh <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt    <= '0;
              rx_dat     <= rx_next;
              rx_vld     <= 1'b1;
              word_start <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (shift_edge) begin
            if (CPHA == 0 && word_start) word_start <= 1'b0;
            if (!load) tx_reg <= tx_shifted;
          end
        end
        default: state <= RESYNC;
      endcase
      miso <= (MSB_FIRST != 0) ? tx_reg[WORD_W-1] : tx_reg[0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_shifter_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_spi_shifter_gen
// Desc   : Self-checking bench; four DUT instances cover modes 0..3 and LSB-first.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_spi_shifter_gen;
  localparam int N     = 4;
  localparam int H     = 8;
  localparam int DEPTH = 2;

  function automatic int f_w(input int i);    return (i == 0) ? 8 : 16; endfunction
  function automatic int f_cpol(input int i); return (i >= 2) ? 1 : 0;  endfunction
  function automatic int f_cpha(input int i); return i % 2;             endfunction
  function automatic int f_msb(input int i);  return (i == 2) ? 0 : 1;  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck [N];
  logic        ssn [N];
  logic        mosi [N];
  logic [31:0] tx_dat [N];
  logic        tx_vld [N];
  logic        miso_a [N];
  logic        oe_a [N];
  logic [31:0] rx_dat_a [N];
  logic        rxv_a [N];
  logic        rdy_a [N];
  logic        start_a [N];
  logic        fend_a [N];
  logic        part_a [N];
  logic        und_a [N];
  logic        ovr_a [N];
  logic        busy_a [N];

  int checks = 0;
  int failures = 0;

  int          rx_n [N];
  int          und_n [N];
  int          ovr_n [N];
  int          part_n [N];
  int          fend_n [N];
  int          start_n [N];
  logic [31:0] rx_last [N];

  // Reference model: tx FIFO contents per instance and expected event totals.
  logic [31:0] mq [N][$];
  int          exp_und [N];
  int          exp_ovr [N];
  logic [31:0] pend [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int WW = f_w(g);
    logic [WW-1:0] rxw;
    spi_shifter_gen #(
      .WORD_W      (WW),
      .CPOL        (f_cpol(g)),
      .CPHA        (f_cpha(g)),
      .MSB_FIRST   (f_msb(g)),
      .TX_DEPTH    (DEPTH),
      .SYNC_STAGES (2)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .sck         (sck[g]),
      .ssn         (ssn[g]),
      .mosi        (mosi[g]),
      .miso        (miso_a[g]),
      .miso_oe     (oe_a[g]),
      .rx_dat      (rxw),
      .rx_vld      (rxv_a[g]),
      .tx_dat      (tx_dat[g][WW-1:0]),
      .tx_vld      (tx_vld[g]),
      .tx_rdy      (rdy_a[g]),
      .start       (start_a[g]),
      .frame_end   (fend_a[g]),
      .rx_partial  (part_a[g]),
      .tx_underrun (und_a[g]),
      .tx_overrun  (ovr_a[g]),
      .busy        (busy_a[g])
    );
    assign rx_dat_a[g] = 32'(rxw);
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rxv_a[i]) begin
        rx_n[i]    <= rx_n[i] + 1;
        rx_last[i] <= rx_dat_a[i];
      end
      if (und_a[i])   und_n[i]   <= und_n[i] + 1;
      if (ovr_a[i])   ovr_n[i]   <= ovr_n[i] + 1;
      if (part_a[i])  part_n[i]  <= part_n[i] + 1;
      if (fend_a[i])  fend_n[i]  <= fend_n[i] + 1;
      if (start_a[i]) start_n[i] <= start_n[i] + 1;
    end
  end

  task automatic model_load(input int i, output logic [31:0] w);
    if (mq[i].size() > 0) begin
      w = mq[i].pop_front();
    end else begin
      w = '0;
      exp_und[i]++;
    end
  endtask

  task automatic push(input int i, input logic [31:0] d);
    @(negedge clk);
    tx_dat[i] = d;
    tx_vld[i] = 1'b1;
    @(posedge clk);
    #1;
    tx_vld[i] = 1'b0;
    if (mq[i].size() < DEPTH) mq[i].push_back(d);
    else exp_ovr[i]++;
  endtask

  task automatic ssn_low(input int i);
    ssn[i] = 1'b0;
    if (f_cpha(i) == 0) model_load(i, pend[i]);
    repeat (H) @(posedge clk);
  endtask

  task automatic ssn_high(input int i);
    ssn[i] = 1'b1;
    repeat (H) @(posedge clk);
  endtask

  // Master side of one word (or a partial word of nbits).
  task automatic xfer(input int i, input int nbits, input logic [31:0] data,
                      output logic [31:0] got, output logic [31:0] exp_tx);
    int          w;
    int          pos;
    logic        cp;
    logic [31:0] cur;
    w   = f_w(i);
    cp  = (f_cpol(i) != 0);
    got = '0;
    if (f_cpha(i) == 1) model_load(i, cur);
    else cur = pend[i];
    for (int b = 0; b < nbits; b++) begin
      pos = (f_msb(i) != 0) ? (w - 1 - b) : b;
      if (f_cpha(i) == 0) begin
        mosi[i] = data[pos];
        repeat (H) @(posedge clk);
        got[pos] = miso_a[i];
        sck[i] = ~cp;
        repeat (H) @(posedge clk);
        sck[i] = cp;
      end else begin
        sck[i] = ~cp;
        mosi[i] = data[pos];
        repeat (H) @(posedge clk);
        got[pos] = miso_a[i];
        sck[i] = cp;
        repeat (H) @(posedge clk);
      end
    end
    repeat (H) @(posedge clk);
    if (f_cpha(i) == 0 && nbits == w) model_load(i, pend[i]);
    exp_tx = cur;
  endtask

  task automatic test_reset;
    logic [41:0] ov;
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      ov = {miso_a[i], oe_a[i], rx_dat_a[i], rxv_a[i], rdy_a[i], start_a[i],
            fend_a[i], part_a[i], und_a[i], ovr_a[i], busy_a[i]};
      checks++;
      if (ov !== 42'h40) begin
        failures++;
        $display("FAIL reset_outputs[%0d]: got %h expected %h", i, ov, 42'h40);
      end
    end
    rst = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_mode0;
    logic [31:0] got, exp;
    int s_rx, s_start, s_fend;
    s_rx = rx_n[0]; s_start = start_n[0]; s_fend = fend_n[0];
    push(0, 32'h3C);
    push(0, 32'hA5);
    ssn_low(0);
    checks++;
    if (start_n[0] !== s_start + 1) begin
      failures++; $display("FAIL mode0_start: got %0d expected %0d", start_n[0], s_start + 1);
    end
    checks++;
    if ({busy_a[0], oe_a[0]} !== 2'b11) begin
      failures++; $display("FAIL mode0_busy_oe: got %b expected 11", {busy_a[0], oe_a[0]});
    end
    xfer(0, 8, 32'hAA, got, exp);
    checks++;
    if (rx_last[0] !== 32'hAA) begin
      failures++; $display("FAIL mode0_rx_w0: got %h expected %h", rx_last[0], 32'hAA);
    end
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL mode0_miso_w0: got %h expected %h", got, exp);
    end
    push(0, 32'h00);
    xfer(0, 8, 32'hAB, got, exp);
    checks++;
    if (rx_last[0] !== 32'hAB) begin
      failures++; $display("FAIL mode0_rx_w1: got %h expected %h", rx_last[0], 32'hAB);
    end
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL mode0_miso_w1: got %h expected %h", got, exp);
    end
    ssn_high(0);
    checks++;
    if (rx_n[0] !== s_rx + 2) begin
      failures++; $display("FAIL mode0_rx_count: got %0d expected %0d", rx_n[0], s_rx + 2);
    end
    checks++;
    if (fend_n[0] !== s_fend + 1 || busy_a[0] !== 1'b0) begin
      failures++; $display("FAIL mode0_frame_end: got %0d/%b expected %0d/0", fend_n[0], busy_a[0], s_fend + 1);
    end
    checks++;
    if (und_n[0] !== 0) begin
      failures++; $display("FAIL mode0_underrun: got %0d expected 0", und_n[0]);
    end
  endtask

  task automatic test_modes16;
    logic [31:0] got, exp;
    for (int i = 1; i < N; i++) begin
      push(i, 32'hBEEF);
      ssn_low(i);
      xfer(i, 16, 32'h1234, got, exp);
      ssn_high(i);
      checks++;
      if (rx_last[i] !== 32'h1234) begin
        failures++; $display("FAIL modes16_rx[%0d]: got %h expected %h", i, rx_last[i], 32'h1234);
      end
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL modes16_miso[%0d]: got %h expected %h", i, got, exp);
      end
      checks++;
      if (und_n[i] !== exp_und[i]) begin
        failures++; $display("FAIL modes16_underrun[%0d]: got %0d expected %0d", i, und_n[i], exp_und[i]);
      end
    end
  endtask

  task automatic test_empty;
    logic [31:0] got, exp;
    int s_und;
    s_und = und_n[1];
    ssn_low(1);
    xfer(1, 16, 32'h0055, got, exp);
    ssn_high(1);
    checks++;
    if (got !== 32'h0) begin
      failures++; $display("FAIL empty_miso: got %h expected %h", got, 32'h0);
    end
    checks++;
    if (und_n[1] !== s_und + 1) begin
      failures++; $display("FAIL empty_underrun: got %0d expected %0d", und_n[1], s_und + 1);
    end
    checks++;
    if (rx_last[1] !== 32'h0055) begin
      failures++; $display("FAIL empty_rx: got %h expected %h", rx_last[1], 32'h0055);
    end
  endtask

  task automatic test_overrun;
    logic [31:0] got, exp;
    logic [31:0] w [3];
    int s_ovr;
    s_ovr = ovr_n[0];
    for (int k = 0; k < 3; k++) w[k] = $urandom & 32'hFF;
    push(0, w[0]);
    push(0, w[1]);
    checks++;
    if (rdy_a[0] !== 1'b0) begin
      failures++; $display("FAIL overrun_rdy: got %b expected 0", rdy_a[0]);
    end
    push(0, w[2]);
    repeat (2) @(posedge clk);
    checks++;
    if (ovr_n[0] !== s_ovr + 1 || ovr_n[0] !== exp_ovr[0]) begin
      failures++; $display("FAIL overrun_pulse: got %0d expected %0d", ovr_n[0], s_ovr + 1);
    end
    ssn_low(0);
    for (int k = 0; k < 2; k++) begin
      xfer(0, 8, $urandom & 32'hFF, got, exp);
      checks++;
      if (got !== w[k] || got !== exp) begin
        failures++; $display("FAIL overrun_order[%0d]: got %h expected %h", k, got, w[k]);
      end
    end
    ssn_high(0);
    checks++;
    if (und_n[0] !== exp_und[0]) begin
      failures++; $display("FAIL overrun_underrun: got %0d expected %0d", und_n[0], exp_und[0]);
    end
  endtask

  task automatic test_partial;
    logic [31:0] got, exp, d;
    int s_rx, s_part, s_fend;
    s_rx = rx_n[0]; s_part = part_n[0]; s_fend = fend_n[0];
    ssn_low(0);
    xfer(0, 5, $urandom & 32'hFF, got, exp);
    ssn_high(0);
    checks++;
    if (part_n[0] !== s_part + 1 || fend_n[0] !== s_fend + 1) begin
      failures++; $display("FAIL partial_pulses: got %0d/%0d expected %0d/%0d",
                           part_n[0], fend_n[0], s_part + 1, s_fend + 1);
    end
    checks++;
    if (rx_n[0] !== s_rx) begin
      failures++; $display("FAIL partial_no_rx: got %0d expected %0d", rx_n[0], s_rx);
    end
    d = $urandom & 32'hFF;
    push(0, 32'h96);
    ssn_low(0);
    xfer(0, 8, d, got, exp);
    ssn_high(0);
    checks++;
    if (rx_last[0] !== d || rx_n[0] !== s_rx + 1) begin
      failures++; $display("FAIL partial_next_rx: got %h expected %h", rx_last[0], d);
    end
    checks++;
    if (got !== exp) begin
      failures++; $display("FAIL partial_next_miso: got %h expected %h", got, exp);
    end
    checks++;
    if (part_n[0] !== s_part + 1) begin
      failures++; $display("FAIL partial_full_frame: got %0d expected %0d", part_n[0], s_part + 1);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] got, exp, d;
    logic [41:0] ov;
    int s_rx, s_start, s_fend;
    ssn_low(0);
    xfer(0, 2, 32'hFF, got, exp);
    mosi[0] = 1'b1;
    repeat (H) @(posedge clk);
    sck[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    ov = {miso_a[0], oe_a[0], rx_dat_a[0], rxv_a[0], rdy_a[0], start_a[0],
          fend_a[0], part_a[0], und_a[0], ovr_a[0], busy_a[0]};
    checks++;
    if (ov !== 42'h40) begin
      failures++; $display("FAIL midreset_outputs: got %h expected %h", ov, 42'h40);
    end
    rst = 1'b0;
    for (int q = 0; q < N; q++) mq[q].delete();
    s_rx = rx_n[0]; s_start = start_n[0]; s_fend = fend_n[0];
    repeat (H) @(posedge clk);
    sck[0] = 1'b0;
    xfer(0, 5, 32'hFF, got, exp);
    ssn_high(0);
    checks++;
    if (rx_n[0] !== s_rx || start_n[0] !== s_start || fend_n[0] !== s_fend) begin
      failures++; $display("FAIL midreset_ignored: got rx=%0d start=%0d fend=%0d expected %0d/%0d/%0d",
                           rx_n[0], start_n[0], fend_n[0], s_rx, s_start, s_fend);
    end
    d = $urandom & 32'hFF;
    push(0, 32'h5A);
    ssn_low(0);
    checks++;
    if (start_n[0] !== s_start + 1) begin
      failures++; $display("FAIL midreset_start: got %0d expected %0d", start_n[0], s_start + 1);
    end
    xfer(0, 8, d, got, exp);
    ssn_high(0);
    checks++;
    if (rx_last[0] !== d || rx_n[0] !== s_rx + 1) begin
      failures++; $display("FAIL midreset_rx: got %h expected %h", rx_last[0], d);
    end
    checks++;
    if (got !== exp || got !== 32'h5A) begin
      failures++; $display("FAIL midreset_miso: got %h expected %h", got, 32'h5A);
    end
  endtask

  task automatic test_random;
    logic [31:0] got, exp, d, mask;
    int i, npush, nw;
    for (int r = 0; r < 10; r++) begin
      i     = $urandom_range(0, N - 1);
      mask  = (f_w(i) == 8) ? 32'hFF : 32'hFFFF;
      npush = $urandom_range(0, 3);
      nw    = $urandom_range(1, 3);
      for (int k = 0; k < npush; k++) push(i, $urandom & mask);
      ssn_low(i);
      for (int k = 0; k < nw; k++) begin
        d = $urandom & mask;
        xfer(i, f_w(i), d, got, exp);
        checks++;
        if (rx_last[i] !== d) begin
          failures++; $display("FAIL random_rx[%0d.%0d]: got %h expected %h", r, k, rx_last[i], d);
        end
        checks++;
        if (got !== exp) begin
          failures++; $display("FAIL random_miso[%0d.%0d]: got %h expected %h", r, k, got, exp);
        end
      end
      ssn_high(i);
      checks++;
      if (und_n[i] !== exp_und[i] || ovr_n[i] !== exp_ovr[i]) begin
        failures++; $display("FAIL random_status[%0d]: got und=%0d ovr=%0d expected und=%0d ovr=%0d",
                             r, und_n[i], ovr_n[i], exp_und[i], exp_ovr[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      sck[i]    = (f_cpol(i) != 0);
      ssn[i]    = 1'b1;
      mosi[i]   = 1'b0;
      tx_dat[i] = '0;
      tx_vld[i] = 1'b0;
    end
    test_reset;
    test_mode0;
    test_modes16;
    test_empty;
    test_overrun;
    test_partial;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
